enemy_tank_ctrl_gen: RTL and testbench

Parametrised next-generation enemy tank controller; one instance per enemy tank, N instances side by side in the game layer.
- Runs a single-clock FSM (DEAD/SPAWN/ALIVE) covering spawn, chase movement on a configurable grid, hit detection, scoring, kill pulse and shot requests.
- Replaces divided-clock movement with a step-tick enable and adds a shell request/busy handshake.
- Outputs feed the renderer, the enemy shell module and the score display.

---
 rtl/tank_pkg.sv | 8 +
 rtl/tank_chase_step.sv | 45 ++++
 rtl/enemy_tank_ctrl_gen.sv | 125 ++++++++++++
 tb/tb_enemy_tank_ctrl_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// tank_pkg: shared direction codes and FSM state type for tank controllers
package tank_pkg;
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  typedef enum logic [1:0] {DEAD, SPAWN, ALIVE} state_t;
endpackage

// File: rtl/tank_chase_step.sv
// tank_chase_step: combinational one-cell chase step toward a target, clipped to the grid
// Ports: i_cur_x/i_cur_y/i_cur_dir current pose, i_tgt_x/i_tgt_y target,
//        o_nx_x/o_nx_y/o_nx_dir next pose, o_aligned target shares exactly one axis.
module tank_chase_step
  import tank_pkg::*;
#(
  parameter int POS_W  = 5,
  parameter int GRID_W = 25,
  parameter int GRID_H = 13
) (
  input  logic [POS_W-1:0] i_cur_x,
  input  logic [POS_W-1:0] i_cur_y,
  input  logic [1:0]       i_cur_dir,
  input  logic [POS_W-1:0] i_tgt_x,
  input  logic [POS_W-1:0] i_tgt_y,
  output logic [POS_W-1:0] o_nx_x,
  output logic [POS_W-1:0] o_nx_y,
  output logic [1:0]       o_nx_dir,
  output logic             o_aligned
);
  localparam logic [POS_W-1:0] X_MAX = POS_W'(GRID_W - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(GRID_H - 1);
  localparam logic [POS_W-1:0] ONE   = POS_W'(1);
  logic [POS_W-1:0] w_dx, w_dy;
  logic             w_right, w_down, w_use_x, w_use_y;
  assign w_right   = i_tgt_x > i_cur_x;
  assign w_down    = i_tgt_y > i_cur_y;
  assign w_dx      = w_right ? i_tgt_x - i_cur_x : i_cur_x - i_tgt_x;
  assign w_dy      = w_down ? i_tgt_y - i_cur_y : i_cur_y - i_tgt_y;
  // Shorter nonzero axis wins; ties go to the y axis.
  assign w_use_x   = (w_dx != '0) && ((w_dy == '0) || (w_dx < w_dy));
  assign w_use_y   = (w_dy != '0) && !w_use_x;
  assign o_aligned = (w_dx == '0) != (w_dy == '0);
  always_comb begin
    o_nx_dir = w_use_x ? (w_right ? DIR_RIGHT : DIR_LEFT)
             : w_use_y ? (w_down ? DIR_DOWN : DIR_UP) : i_cur_dir;
    // Steps that would leave the grid are dropped while the heading still turns.
    o_nx_x = !w_use_x ? i_cur_x
           : w_right ? ((i_cur_x < X_MAX) ? i_cur_x + ONE : i_cur_x)
           : ((i_cur_x != '0) ? i_cur_x - ONE : i_cur_x);
    o_nx_y = !w_use_y ? i_cur_y
           : w_down ? ((i_cur_y < Y_MAX) ? i_cur_y + ONE : i_cur_y)
           : ((i_cur_y != '0) ? i_cur_y - ONE : i_cur_y);
  end
endmodule

// File: rtl/enemy_tank_ctrl_gen.sv
// enemy_tank_ctrl_gen: per-tank DEAD/SPAWN/ALIVE controller with chase, hit, score, kill pulse and shot requests
// Inputs: clk, rst_n (async, active-low), enable, step_tick, respawn_en, spawn_x/y, my_x/y/dir,
//         shell_x/y/valid, frozen, laser, eshell_busy.
// Outputs: fire_req, alive, tank_x/y/dir, score, kill.
// Build option LASER_EN: when defined, a facing player with laser active kills tanks on its row/column.
module enemy_tank_ctrl_gen
  import tank_pkg::*;
#(
  parameter int POS_W       = 5,
  parameter int GRID_W      = 25,
  parameter int GRID_H      = 13,
  parameter int SCORE_W     = 7,
  parameter int KILL_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               step_tick,
  input  logic               respawn_en,
  input  logic [POS_W-1:0]   spawn_x,
  input  logic [POS_W-1:0]   spawn_y,
  input  logic [POS_W-1:0]   my_x,
  input  logic [POS_W-1:0]   my_y,
  input  logic [1:0]         my_dir,
  input  logic [POS_W-1:0]   shell_x,
  input  logic [POS_W-1:0]   shell_y,
  input  logic               shell_valid,
  input  logic               frozen,
  input  logic               laser,
  input  logic               eshell_busy,
  output logic               fire_req,
  output logic               alive,
  output logic [POS_W-1:0]   tank_x,
  output logic [POS_W-1:0]   tank_y,
  output logic [1:0]         tank_dir,
  output logic [SCORE_W-1:0] score,
  output logic               kill
);
  localparam int KC_W = $clog2(KILL_CYCLES + 1);
  localparam logic [KC_W-1:0] KC_LOAD = KC_W'(KILL_CYCLES);
  localparam logic [KC_W-1:0] KC_ONE  = KC_W'(1);
  state_t             r_state, w_state_nx;
  logic [POS_W-1:0]   r_tank_x, r_tank_y, w_nx_x, w_nx_y;
  logic [1:0]         r_tank_dir, w_nx_dir;
  logic [SCORE_W-1:0] r_score;
  logic [KC_W-1:0]    r_kill_cnt;
  logic               r_fire, w_aligned, w_alive, w_body_hit, w_laser_hit, w_hit;
  logic               w_on_spawn, w_kill_start, w_step;
  tank_chase_step #(.POS_W(POS_W), .GRID_W(GRID_W), .GRID_H(GRID_H)) u_step (
    .i_cur_x  (r_tank_x),
    .i_cur_y  (r_tank_y),
    .i_cur_dir(r_tank_dir),
    .i_tgt_x  (my_x),
    .i_tgt_y  (my_y),
    .o_nx_x   (w_nx_x),
    .o_nx_y   (w_nx_y),
    .o_nx_dir (w_nx_dir),
    .o_aligned(w_aligned)
  );
`ifdef LASER_EN
  // The beam covers the half-line in front of the player along its heading.
  assign w_laser_hit = laser && (
      ((r_tank_x == my_x) && (((my_dir == DIR_UP) && (r_tank_y <= my_y)) ||
                              ((my_dir == DIR_DOWN) && (r_tank_y >= my_y)))) ||
      ((r_tank_y == my_y) && (((my_dir == DIR_LEFT) && (r_tank_x <= my_x)) ||
                              ((my_dir == DIR_RIGHT) && (r_tank_x >= my_x)))));
`else
  logic w_unused_laser;
  assign w_unused_laser = ^{laser, my_dir};
  assign w_laser_hit    = 1'b0;
`endif
  assign w_alive      = r_state == ALIVE;
  assign w_body_hit   = ((r_tank_x == my_x) && (r_tank_y == my_y)) ||
                        (shell_valid && (r_tank_x == shell_x) && (r_tank_y == shell_y));
  assign w_hit        = w_alive && (w_body_hit || w_laser_hit);
  // Kills on the spawn cell are not credited, which stops spawn camping.
  assign w_on_spawn   = (r_tank_x == spawn_x) && (r_tank_y == spawn_y);
  assign w_kill_start = w_hit && !w_on_spawn;
  assign w_step       = w_alive && step_tick && !frozen && !w_hit;
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = !enable ? DEAD
               : (r_state == DEAD) ? (respawn_en ? SPAWN : DEAD)
               : (r_state == SPAWN) ? ALIVE
               : (w_hit ? DEAD : ALIVE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DEAD;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tank_x   <= '0;
      r_tank_y   <= '0;
      r_tank_dir <= DIR_UP;
      r_score    <= '0;
      r_fire     <= 1'b0;
      r_kill_cnt <= '0;
    end else if (!enable) begin
      r_score    <= '0;
      r_fire     <= 1'b0;
      r_kill_cnt <= '0;
    end else begin
      r_fire     <= w_step && w_aligned && !eshell_busy;
      r_kill_cnt <= w_kill_start ? KC_LOAD : (r_kill_cnt != '0) ? r_kill_cnt - KC_ONE : r_kill_cnt;
      if (w_kill_start && (r_score != '1)) r_score <= r_score + SCORE_W'(1);
      if ((r_state == DEAD) && respawn_en) begin
        r_tank_x   <= spawn_x;
        r_tank_y   <= spawn_y;
        r_tank_dir <= DIR_DOWN;
      end else if (w_step) begin
        r_tank_x   <= w_nx_x;
        r_tank_y   <= w_nx_y;
        r_tank_dir <= w_nx_dir;
      end
    end
  end
  assign fire_req = r_fire;
  assign alive    = w_alive;
  assign tank_x   = r_tank_x;
  assign tank_y   = r_tank_y;
  assign tank_dir = r_tank_dir;
  assign score    = r_score;
  assign kill     = r_kill_cnt != '0;
endmodule

// File: tb/tb_enemy_tank_ctrl_gen.sv
// tb_enemy_tank_ctrl_gen: directed scoreboard bench for enemy_tank_ctrl_gen
module tb_enemy_tank_ctrl_gen;
  localparam int POS_W = 5;
  localparam int SCORE_W = 7;
  localparam int KC = 16;
  logic clk = 0, rst_n = 0, enable = 0, step_tick = 0, respawn_en = 0;
  logic shell_valid = 0, frozen = 0, laser = 0, eshell_busy = 0;
  logic [POS_W-1:0] spawn_x = 0, spawn_y = 0, my_x = 20, my_y = 12, shell_x = 0, shell_y = 0;
  logic [1:0] my_dir = 0;
  logic fire_req, alive, kill;
  logic [POS_W-1:0] tank_x, tank_y;
  logic [1:0] tank_dir;
  logic [SCORE_W-1:0] score;
  int passed = 0, total = 0;
  string tq[$];
  logic [31:0] eq[$];
  always #5 clk = ~clk;
  enemy_tank_ctrl_gen #(.POS_W(POS_W), .GRID_W(25), .GRID_H(13), .SCORE_W(SCORE_W), .KILL_CYCLES(KC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .step_tick(step_tick), .respawn_en(respawn_en),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .my_x(my_x), .my_y(my_y), .my_dir(my_dir),
    .shell_x(shell_x), .shell_y(shell_y), .shell_valid(shell_valid), .frozen(frozen),
    .laser(laser), .eshell_busy(eshell_busy), .fire_req(fire_req), .alive(alive),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .score(score), .kill(kill)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input string t, input logic [31:0] v);
    tq.push_back(t);
    eq.push_back(v);
  endtask
  task automatic pop_chk(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    total++;
    if (eq.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%0d", obs);
      return;
    end
    t = tq.pop_front();
    e = eq.pop_front();
    assert (obs === e) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
  endtask
  task automatic respawn_at(input logic [POS_W-1:0] x, input logic [POS_W-1:0] y);
    spawn_x = x;
    spawn_y = y;
    respawn_en = 1;
    tick();
    respawn_en = 0;
    tick();
  endtask
  initial begin
    int n;
    repeat (2) tick();
    push_exp("rst_alive", 0); push_exp("rst_x", 0); push_exp("rst_y", 0); push_exp("rst_dir", 0);
    push_exp("rst_score", 0); push_exp("rst_kill", 0); push_exp("rst_fire", 0);
    pop_chk(alive); pop_chk(tank_x); pop_chk(tank_y); pop_chk(tank_dir);
    pop_chk(score); pop_chk(kill); pop_chk(fire_req);
    rst_n = 1;
    enable = 1;
    spawn_x = 0; spawn_y = 0; respawn_en = 1;
    push_exp("spawn_not_alive", 0);
    tick();
    respawn_en = 0;
    pop_chk(alive);
    push_exp("alive_after_spawn", 1); push_exp("spawn_x", 0); push_exp("spawn_y", 0);
    push_exp("spawn_dir", 1); push_exp("spawn_score", 0);
    tick();
    pop_chk(alive); pop_chk(tank_x); pop_chk(tank_y); pop_chk(tank_dir); pop_chk(score);
    shell_x = 0; shell_y = 0; shell_valid = 1;
    push_exp("spawnhit_alive", 0); push_exp("spawnhit_score", 0); push_exp("spawnhit_kill", 0);
    tick();
    shell_valid = 0;
    pop_chk(alive); pop_chk(score); pop_chk(kill);
    my_x = 5; my_y = 8;
    respawn_at(5, 3);
    push_exp("b_alive", 1);
    pop_chk(alive);
    step_tick = 1;
    push_exp("chase_x", 5); push_exp("chase_y", 4); push_exp("chase_dir", 1); push_exp("chase_fire", 1);
    tick();
    step_tick = 0;
    pop_chk(tank_x); pop_chk(tank_y); pop_chk(tank_dir); pop_chk(fire_req);
    push_exp("fire_one_cycle", 0);
    tick();
    pop_chk(fire_req);
    eshell_busy = 1; step_tick = 1;
    push_exp("busy_y", 5); push_exp("busy_fire", 0);
    tick();
    step_tick = 0;
    pop_chk(tank_y); pop_chk(fire_req);
    push_exp("busy_fire_late", 0);
    tick();
    pop_chk(fire_req);
    eshell_busy = 0;
    frozen = 1; step_tick = 1;
    repeat (10) tick();
    step_tick = 0; frozen = 0;
    push_exp("frozen_x", 5); push_exp("frozen_y", 5);
    pop_chk(tank_x); pop_chk(tank_y);
    enable = 0;
    push_exp("dis_alive", 0); push_exp("dis_x", 5); push_exp("dis_y", 5); push_exp("dis_score", 0);
    tick();
    pop_chk(alive); pop_chk(tank_x); pop_chk(tank_y); pop_chk(score);
    enable = 1;
    my_x = 10; my_y = 12;
    respawn_at(10, 5);
    step_tick = 1;
    push_exp("d_y", 6); push_exp("d_fire", 1);
    tick();
    step_tick = 0;
    pop_chk(tank_y); pop_chk(fire_req);
    shell_x = 10; shell_y = 6; shell_valid = 1;
    push_exp("hit_alive", 0); push_exp("hit_score", 1); push_exp("hit_kill", 1);
    tick();
    shell_valid = 0;
    pop_chk(alive); pop_chk(score); pop_chk(kill);
    n = 1;
    while (n < 40) begin
      tick();
      if (!kill) break;
      n++;
    end
    push_exp("kill_len", KC);
    pop_chk(n);
    my_x = 26; my_y = 2;
    respawn_at(24, 2);
    step_tick = 1;
    push_exp("edge_x", 24); push_exp("edge_dir", 3); push_exp("edge_alive", 1); push_exp("edge_fire", 1);
    tick();
    step_tick = 0;
    pop_chk(tank_x); pop_chk(tank_dir); pop_chk(alive); pop_chk(fire_req);
    spawn_x = 3; respawn_en = 1;
    push_exp("respawn_ign_x", 24); push_exp("respawn_ign_alive", 1);
    tick();
    respawn_en = 0; spawn_x = 24;
    pop_chk(tank_x); pop_chk(alive);
    shell_x = 24; shell_y = 2; shell_valid = 1;
    push_exp("e_alive", 0); push_exp("e_score", 1); push_exp("e_kill", 0);
    tick();
    shell_valid = 0;
    pop_chk(alive); pop_chk(score); pop_chk(kill);
    my_x = 2; my_y = 4; my_dir = 2'b11;
    respawn_at(9, 3);
    step_tick = 1;
    push_exp("f_y", 4); push_exp("f_x", 9); push_exp("f_dir", 1); push_exp("f_fire", 0);
    tick();
    step_tick = 0;
    pop_chk(tank_y); pop_chk(tank_x); pop_chk(tank_dir); pop_chk(fire_req);
    laser = 1;
`ifdef LASER_EN
    push_exp("laser_alive", 0); push_exp("laser_score", 2); push_exp("laser_kill", 1);
`else
    push_exp("laser_alive", 1); push_exp("laser_score", 1); push_exp("laser_kill", 0);
`endif
    tick();
    laser = 0;
    pop_chk(alive); pop_chk(score); pop_chk(kill);
    #2 rst_n = 0;
    #1;
    push_exp("arst_alive", 0); push_exp("arst_score", 0); push_exp("arst_kill", 0); push_exp("arst_x", 0);
    pop_chk(alive); pop_chk(score); pop_chk(kill); pop_chk(tank_x);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
